pcie_lane_scrambler: RTL and testbench
======================================

Name: pcie_lane_scrambler

Overview:
Multi-lane, parametrised PCIe TX scrambler that replaces the single-lane 8/16/32-bit scrambler. It sits between the per-lane byte stripper / ordered-set generator and the PIPE TX interface. Gen1/2 uses the 16-bit 8b/10b LFSR with COM reset and SKP hold. Gen3 uses the 23-bit 128b/130b per-lane seeded LFSR with sync-header and ordered-set-aware scrambling. Output is registered with a fixed one-cycle latency.

Parameters:
LANES, 4, number of lanes (1..16).
SYMS, 4, symbols (bytes) per lane per cycle; legal values 1, 2, 4; must divide 16.

Ports:
pclk  in  1  PIPE clock
reset_n  in  1  async active-low reset
gen  in  3  link rate: 1, 2, 3; values >3 are treated as 3
scr_disable  in  1  training "disable scrambling"; data passes through unscrambled, LFSR still tracks
in_valid  in  1  input beat valid
in_data  in  LANES*SYMS*8  lane l, symbol s at bits [(l*SYMS+s)*8 +: 8]
in_k  in  LANES*SYMS  K flag per symbol (Gen1/2 only)
in_block_start  in  1  Gen3: first beat of a 16-symbol block (all lanes aligned)
in_sync  in  LANES*2  Gen3 sync header per lane, sampled on in_block_start
lane_seed  in  LANES*23  Gen3 per-lane LFSR seed
out_valid  out  1  registered in_valid
out_data  out  LANES*SYMS*8  scrambled data
out_k  out  LANES*SYMS  registered in_k
out_block_start  out  1  registered in_block_start
out_sync  out  LANES*2  registered sync header
err_misalign  out  1  sticky: in_block_start seen while symbol counter != 0

Behaviour:
- Reset: reset_n is asynchronous, active-low; clock is pclk. All outputs reset to 0. Gen1/2 LFSRs reset to 16'hFFFF; Gen3 LFSRs load lane_seed; symbol counter resets to 0.
- Latency: exactly 1 pclk from input to output. When in_valid=0, LFSR, counter and sync state hold, and out_valid=0 on the next cycle.
- Gen1/2, per symbol, in ascending order within a beat; the LFSR chains combinationally across the SYMS symbols:
  - K=1, 0xBC (COM): unscrambled; LFSR reloads 16'hFFFF for the next symbol.
  - K=1, 0x1C (SKP): unscrambled; LFSR does not advance.
  - Other K: unscrambled; LFSR advances 8 bits.
  - D: XOR with LFSR output byte; LFSR advances 8 bits.
  - Polynomial G(x) = x^16+x^5+x^4+x^3+1, Galois form per PCIe base spec.
- Gen3: a 16-symbol block spans 16/SYMS beats.
  - The symbol counter (0..15, step SYMS, wraps to 0) advances on valid beats.
  - in_block_start forces the counter to 0 and latches per-lane in_sync plus the symbol-0 type.
  - Sync 2'b01 (data block): all symbols scrambled; LFSR advances per symbol.
  - Sync 2'b10, symbol 0 = 0xAA (SKP OS): no scrambling; LFSR holds for the whole block.
  - Sync 2'b10, symbol 0 = 0x00 (EIEOS): no scrambling; LFSR reloads lane_seed after the block's last symbol.
  - Other OS: symbol 0 unscrambled; symbols 1..15 scrambled; LFSR advances on all 16 symbols.
  - Invalid sync (00/11): pass through unscrambled; LFSR advances.
  - Polynomial G(x) = x^23+x^21+x^16+x^8+x^5+x^2+1.
- scr_disable=1: out_data = in_data; LFSR update rules are unchanged.
- gen change: detected by comparing with a registered copy. On the cycle it differs, all LFSRs reload (FFFF or seed) and the counter clears; that beat is processed with the reloaded state.
- Misalign: in_block_start with counter != 0 sets err_misalign (sticky until reset), and the block restarts from that beat.
- Simultaneous events: COM followed by SKP in the same beat → SKP unscrambled, LFSR stays FFFF. EIEOS end coinciding with the next in_block_start → the new block uses the seed.
- Reset mid-block: the state is fully discarded; the first in_block_start after reset is not a misalign.

Optional Feature:
PCIE_SCR_DBG_EN: when defined, adds output dbg_lfsr (LANES*23): current LFSR state per lane, zero-extended for Gen1/2, registered alongside out_data. When undefined, the port and its registers are absent; there is no other behavioural difference.

Decomposition:
- Package pcie_scr_pkg:
  - Gen1/2 and Gen3 polynomial tap constants.
  - GEN12_SEED = 16'hFFFF.
  - Symbol codes: COM = 8'hBC, SKP = 8'h1C, SKPOS_ID = 8'hAA, EIEOS_ID = 8'h00.
  - SYNC_DATA = 2'b01, SYNC_OS = 2'b10.
  - Default lane seeds: 1DBFBC, 0607BB, 1EC760, 18C0DB, 010F12, 19CFC9, 0277CE, 1BB807, repeating.
  - Block-type enum: DATA, OS, SKPOS, EIEOS, BAD.
- One sub-module pcie_scr_lane, instantiated LANES times. It holds the lane's LFSR and applies the per-symbol rules for SYMS symbols. The top level owns the shared counter, gen tracking, misalign flag and output register.

Test Plan:
- Gen1, LANES=1, SYMS=1: COM then eight D 0x00 → out: BC, then FF 17 C0 14 B2 E7 02 82.
- Gen1, SYMS=4: beat {COM, SKP, SKP, SKP} then D 0x00 ×4 → first beat unchanged; next beat FF 17 C0 14, since SKP does not advance the LFSR.
- Gen3, LANES=2 with default seeds: data block of all 0x00 → each lane's output equals its seeded LFSR stream. Lanes must differ and match the C model.
- Gen3: SKP OS block between two data blocks → SKP OS bytes pass unchanged; the second data block continues the stream as if the SKP OS were absent.
- Gen3: EIEOS block, then a data block → the data block output restarts from lane_seed; TS1 symbol 0 appears unscrambled (0x1E).
- Gen3, SYMS=4: in_block_start on the 2nd beat of a block → err_misalign=1 and stays 1. Then gen 3→1 → LFSR reloads FFFF, first D 0x00 gives FF.

Source files
------------

// File: rtl/pcie_scr_pkg.sv
// pcie_scr_pkg: shared constants, block-type enum and LFSR helpers for the
// multi-lane PCIe TX scrambler (pcie_lane_scrambler / pcie_scr_lane).
//   Gen1/2 : 16-bit Galois LFSR, x^16+x^5+x^4+x^3+1, seed 16'hFFFF
//   Gen3   : 23-bit Galois LFSR, x^23+x^21+x^16+x^8+x^5+x^2+1, per-lane seed
// Keystream bits come out of the LFSR MSB and are applied LSB-first to
// each data byte.
package pcie_scr_pkg;

  // Feedback masks: the polynomial terms below the top degree.
  localparam logic [15:0] GEN12_TAPS = 16'h0039;   // x^5 x^4 x^3 1
  localparam logic [22:0] GEN3_TAPS  = 23'h210125; // x^21 x^16 x^8 x^5 x^2 1
  localparam logic [15:0] GEN12_SEED = 16'hFFFF;

  localparam logic [7:0] COM      = 8'hBC;
  localparam logic [7:0] SKP      = 8'h1C;
  localparam logic [7:0] SKPOS_ID = 8'hAA;
  localparam logic [7:0] EIEOS_ID = 8'h00;

  localparam logic [1:0] SYNC_DATA = 2'b01;
  localparam logic [1:0] SYNC_OS   = 2'b10;

  typedef enum logic [2:0] {
    DATA,
    OS,
    SKPOS,
    EIEOS,
    BAD
  } blk_t;

  // Default Gen3 lane seeds; the table repeats every 8 lanes.
  function automatic logic [22:0] default_seed(input int unsigned lane);
    logic [2:0] idx;
    idx = lane[2:0];
    case (idx)
      3'd0:    return 23'h1DBFBC;
      3'd1:    return 23'h0607BB;
      3'd2:    return 23'h1EC760;
      3'd3:    return 23'h18C0DB;
      3'd4:    return 23'h010F12;
      3'd5:    return 23'h19CFC9;
      3'd6:    return 23'h0277CE;
      default: return 23'h1BB807;
    endcase
  endfunction

  function automatic logic [7:0] g12_key(input logic [15:0] st);
    logic [15:0] s;
    logic [7:0]  k;
    s = st;
    k = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      k[i] = s[15];
      s    = {s[14:0], 1'b0} ^ (s[15] ? GEN12_TAPS : 16'h0000);
    end
    return k;
  endfunction

  function automatic logic [15:0] g12_adv(input logic [15:0] st);
    logic [15:0] s;
    s = st;
    for (int unsigned i = 0; i < 8; i++)
      s = {s[14:0], 1'b0} ^ (s[15] ? GEN12_TAPS : 16'h0000);
    return s;
  endfunction

  function automatic logic [7:0] g3_key(input logic [22:0] st);
    logic [22:0] s;
    logic [7:0]  k;
    s = st;
    k = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      k[i] = s[22];
      s    = {s[21:0], 1'b0} ^ (s[22] ? GEN3_TAPS : 23'h000000);
    end
    return k;
  endfunction

  function automatic logic [22:0] g3_adv(input logic [22:0] st);
    logic [22:0] s;
    s = st;
    for (int unsigned i = 0; i < 8; i++)
      s = {s[21:0], 1'b0} ^ (s[22] ? GEN3_TAPS : 23'h000000);
    return s;
  endfunction

  // Classify a Gen3 block from its sync header and symbol 0.
  function automatic blk_t blk_type(input logic [1:0] sync, input logic [7:0] sym0);
    if (sync == SYNC_DATA) return DATA;
    if (sync == SYNC_OS) begin
      if (sym0 == SKPOS_ID) return SKPOS;
      if (sym0 == EIEOS_ID) return EIEOS;
      return OS;
    end
    return BAD;
  endfunction

endpackage

// File: rtl/pcie_scr_lane.sv
// pcie_scr_lane: one lane of the PCIe TX scrambler. Holds the lane's Gen1/2
// and Gen3 LFSRs plus the latched Gen3 block type, and scrambles SYMS
// symbols per beat. Output data is combinational; the top registers it.
// Optional debug port o_lfsr exists only with PCIE_SCR_DBG_EN defined.
// Ports:
//   pclk, reset_n  clock, async active-low reset
//   i_valid        beat valid (state only moves on valid beats)
//   i_gen3         Gen3 rules when 1, Gen1/2 rules when 0
//   i_reload       gen changed: use reloaded LFSR state for this beat
//   i_start        Gen3 block start on this beat
//   i_disable      pass data through; LFSR still tracks
//   i_cnt          symbol position of this beat's first symbol (0..15)
//   i_sync         lane sync header
//   i_seed         lane Gen3 seed
//   i_data/i_k     lane symbols and K flags
//   o_data         scrambled lane symbols
//   o_lfsr         (debug) LFSR state used for this beat
module pcie_scr_lane
  import pcie_scr_pkg::*;
#(
  parameter int unsigned SYMS = 4
) (
  input  logic                pclk,
  input  logic                reset_n,
  input  logic                i_valid,
  input  logic                i_gen3,
  input  logic                i_reload,
  input  logic                i_start,
  input  logic                i_disable,
  input  logic [3:0]          i_cnt,
  input  logic [1:0]          i_sync,
  input  logic [22:0]         i_seed,
  input  logic [SYMS*8-1:0]   i_data,
  input  logic [SYMS-1:0]     i_k,
  output logic [SYMS*8-1:0]   o_data
`ifdef PCIE_SCR_DBG_EN
  ,
  output logic [22:0]         o_lfsr
`endif
);

  logic [15:0] r_lfsr12;
  logic [22:0] r_lfsr3;
  // r_seeded=0 means the Gen3 LFSR is "at seed"; the seed is taken live
  // from i_seed so reset does not need to load a port value.
  logic        r_seeded;
  blk_t        r_type;

  logic [15:0] w_l12_cur, w_l12_nxt;
  logic [22:0] w_l3_cur, w_l3_nxt;
  blk_t        w_type_new, w_type;
  logic [7:0]  w_sym, w_key;
  logic [3:0]  w_pos;
  logic        w_scr, w_adv;

  always_comb begin
    w_l12_cur  = i_reload ? GEN12_SEED : r_lfsr12;
    w_l3_cur   = (i_reload || !r_seeded) ? i_seed : r_lfsr3;
    w_type_new = blk_type(i_sync, i_data[7:0]);
    w_type     = i_start ? w_type_new : r_type;
    w_l12_nxt  = w_l12_cur;
    w_l3_nxt   = w_l3_cur;
    o_data     = i_data;
    w_sym      = '0;
    w_key      = '0;
    w_pos      = '0;
    w_scr      = 1'b0;
    w_adv      = 1'b0;
    for (int unsigned s = 0; s < SYMS; s++) begin
      w_sym = i_data[s*8 +: 8];
      w_key = '0;
      w_scr = 1'b0;
      w_adv = 1'b0;
      w_pos = i_cnt + 4'(s);
      if (!i_gen3) begin
        if (i_k[s] && (w_sym == COM)) begin
          w_l12_nxt = GEN12_SEED;
        end else if (!(i_k[s] && (w_sym == SKP))) begin
          w_scr     = !i_k[s];
          w_key     = g12_key(w_l12_nxt);
          w_l12_nxt = g12_adv(w_l12_nxt);
        end
      end else begin
        case (w_type)
          DATA:    begin w_scr = 1'b1;             w_adv = 1'b1; end
          OS:      begin w_scr = (w_pos != 4'd0);  w_adv = 1'b1; end
          SKPOS:   begin w_scr = 1'b0;             w_adv = 1'b0; end
          EIEOS:   begin w_scr = 1'b0;             w_adv = 1'b1; end
          default: begin w_scr = 1'b0;             w_adv = 1'b1; end
        endcase
        if (w_adv) begin
          w_key    = g3_key(w_l3_nxt);
          w_l3_nxt = g3_adv(w_l3_nxt);
        end
        if ((w_type == EIEOS) && (w_pos == 4'd15))
          w_l3_nxt = i_seed;
      end
      if (w_scr && !i_disable)
        o_data[s*8 +: 8] = w_sym ^ w_key;
    end
  end

`ifdef PCIE_SCR_DBG_EN
  assign o_lfsr = i_gen3 ? w_l3_cur : {7'd0, w_l12_cur};
`endif

  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) begin
      r_lfsr12 <= GEN12_SEED;
      r_lfsr3  <= '0;
      r_seeded <= 1'b0;
      r_type   <= BAD;
    end else if (i_valid) begin
      if (i_gen3) begin
        r_lfsr3  <= w_l3_nxt;
        r_seeded <= 1'b1;
        if (i_reload) r_lfsr12 <= GEN12_SEED;
        if (i_start)  r_type   <= w_type_new;
      end else begin
        r_lfsr12 <= w_l12_nxt;
        if (i_reload) r_seeded <= 1'b0;
      end
    end else if (i_reload) begin
      r_lfsr12 <= GEN12_SEED;
      r_seeded <= 1'b0;
    end
  end

endmodule

// File: rtl/pcie_lane_scrambler.sv
// pcie_lane_scrambler: multi-lane PCIe TX scrambler between the byte
// stripper / ordered-set generator and the PIPE TX interface. Gen1/2 uses
// the 8b/10b LFSR (COM reset, SKP hold); Gen3 uses per-lane seeded
// 128b/130b LFSRs with block-type aware scrambling. Fixed 1-cycle latency.
// Optional feature macro: PCIE_SCR_DBG_EN adds dbg_lfsr (LANES*23).
// Ports:
//   pclk, reset_n    clock, async active-low reset
//   gen              link rate (1,2,3; >3 treated as 3)
//   scr_disable      pass-through, LFSR keeps tracking
//   in_valid/in_data/in_k/in_block_start/in_sync/lane_seed   input beat
//   out_valid/out_data/out_k/out_block_start/out_sync        registered out
//   err_misalign     sticky: block start seen mid-block
//   dbg_lfsr         (debug) per-lane LFSR state, Gen1/2 zero-extended
module pcie_lane_scrambler
  import pcie_scr_pkg::*;
#(
  parameter int unsigned LANES = 4,
  parameter int unsigned SYMS  = 4
) (
  input  logic                    pclk,
  input  logic                    reset_n,
  input  logic [2:0]              gen,
  input  logic                    scr_disable,
  input  logic                    in_valid,
  input  logic [LANES*SYMS*8-1:0] in_data,
  input  logic [LANES*SYMS-1:0]   in_k,
  input  logic                    in_block_start,
  input  logic [LANES*2-1:0]      in_sync,
  input  logic [LANES*23-1:0]     lane_seed,
  output logic                    out_valid,
  output logic [LANES*SYMS*8-1:0] out_data,
  output logic [LANES*SYMS-1:0]   out_k,
  output logic                    out_block_start,
  output logic [LANES*2-1:0]      out_sync,
  output logic                    err_misalign
`ifdef PCIE_SCR_DBG_EN
  ,
  output logic [LANES*23-1:0]     dbg_lfsr
`endif
);

  logic [1:0]              r_gen;
  logic [3:0]              r_cnt;
  logic                    r_err;
  logic                    r_out_valid;
  logic [LANES*SYMS*8-1:0] r_out_data;
  logic [LANES*SYMS-1:0]   r_out_k;
  logic                    r_out_bs;
  logic [LANES*2-1:0]      r_out_sync;

  logic [1:0]              w_gen_n;
  logic                    w_gen3;
  logic                    w_reload;
  logic                    w_start;
  logic                    w_misalign;
  logic [3:0]              w_cnt;
  logic [LANES*SYMS*8-1:0] w_data;

  assign w_gen_n    = (gen > 3'd3) ? 2'd3 : gen[1:0];
  assign w_gen3     = (w_gen_n == 2'd3);
  assign w_reload   = (w_gen_n != r_gen);
  assign w_start    = in_valid && in_block_start && w_gen3;
  // A gen change clears the counter first, so a block start on that same
  // beat is aligned by definition.
  assign w_misalign = w_start && !w_reload && (r_cnt != 4'd0);
  assign w_cnt      = (w_reload || w_start) ? 4'd0 : r_cnt;

`ifdef PCIE_SCR_DBG_EN
  logic [LANES*23-1:0] w_lfsr;
  logic [LANES*23-1:0] r_dbg;
  assign dbg_lfsr = r_dbg;
`endif

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    pcie_scr_lane #(
      .SYMS(SYMS)
    ) u_lane (
      .pclk      (pclk),
      .reset_n   (reset_n),
      .i_valid   (in_valid),
      .i_gen3    (w_gen3),
      .i_reload  (w_reload),
      .i_start   (w_start),
      .i_disable (scr_disable),
      .i_cnt     (w_cnt),
      .i_sync    (in_sync[l*2 +: 2]),
      .i_seed    (lane_seed[l*23 +: 23]),
      .i_data    (in_data[l*SYMS*8 +: SYMS*8]),
      .i_k       (in_k[l*SYMS +: SYMS]),
      .o_data    (w_data[l*SYMS*8 +: SYMS*8])
`ifdef PCIE_SCR_DBG_EN
      ,
      .o_lfsr    (w_lfsr[l*23 +: 23])
`endif
    );
  end

  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) begin
      r_gen       <= '0;
      r_cnt       <= '0;
      r_err       <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_k     <= '0;
      r_out_bs    <= 1'b0;
      r_out_sync  <= '0;
`ifdef PCIE_SCR_DBG_EN
      r_dbg       <= '0;
`endif
    end else begin
      r_gen       <= w_gen_n;
      r_out_valid <= in_valid;
      r_out_data  <= w_data;
      r_out_k     <= in_k;
      r_out_bs    <= in_block_start;
      r_out_sync  <= in_sync;
      if (w_misalign) r_err <= 1'b1;
      if (in_valid)      r_cnt <= w_cnt + 4'(SYMS);
      else if (w_reload) r_cnt <= '0;
`ifdef PCIE_SCR_DBG_EN
      r_dbg       <= w_lfsr;
`endif
    end
  end

  assign out_valid       = r_out_valid;
  assign out_data        = r_out_data;
  assign out_k           = r_out_k;
  assign out_block_start = r_out_bs;
  assign out_sync        = r_out_sync;
  assign err_misalign    = r_err;

endmodule

// File: tb/tb_pcie_lane_scrambler.sv
// Directed bench: instance A (1 lane, 1 symbol) for the Gen1 reference
// sequence, instance B (2 lanes, 4 symbols) for Gen1 beats, Gen3 block
// types, misalign, gen switching and reset mid-block.
module tb_pcie_lane_scrambler;

  logic pclk = 1'b0;
  logic reset_n;
  always #5 pclk = ~pclk;

  // Instance A
  logic [2:0]  a_gen;
  logic        a_dis, a_valid, a_bs;
  logic [7:0]  a_data;
  logic [0:0]  a_k;
  logic [1:0]  a_sync;
  logic [22:0] a_seed;
  logic        a_ovalid, a_obs, a_err;
  logic [7:0]  a_odata;
  logic [0:0]  a_ok;
  logic [1:0]  a_osync;

  // Instance B
  logic [2:0]  b_gen;
  logic        b_dis, b_valid, b_bs;
  logic [63:0] b_data;
  logic [7:0]  b_k;
  logic [3:0]  b_sync;
  logic [45:0] b_seed;
  logic        b_ovalid, b_obs, b_err;
  logic [63:0] b_odata;
  logic [7:0]  b_ok;
  logic [3:0]  b_osync;

`ifdef PCIE_SCR_DBG_EN
  logic [22:0] a_dbg;
  logic [45:0] b_dbg;
`endif

  pcie_lane_scrambler #(.LANES(1), .SYMS(1)) u_dut_a (
    .pclk(pclk), .reset_n(reset_n), .gen(a_gen), .scr_disable(a_dis),
    .in_valid(a_valid), .in_data(a_data), .in_k(a_k), .in_block_start(a_bs),
    .in_sync(a_sync), .lane_seed(a_seed), .out_valid(a_ovalid), .out_data(a_odata),
    .out_k(a_ok), .out_block_start(a_obs), .out_sync(a_osync), .err_misalign(a_err)
`ifdef PCIE_SCR_DBG_EN
    , .dbg_lfsr(a_dbg)
`endif
  );

  pcie_lane_scrambler #(.LANES(2), .SYMS(4)) u_dut_b (
    .pclk(pclk), .reset_n(reset_n), .gen(b_gen), .scr_disable(b_dis),
    .in_valid(b_valid), .in_data(b_data), .in_k(b_k), .in_block_start(b_bs),
    .in_sync(b_sync), .lane_seed(b_seed), .out_valid(b_ovalid), .out_data(b_odata),
    .out_k(b_ok), .out_block_start(b_obs), .out_sync(b_osync), .err_misalign(b_err)
`ifdef PCIE_SCR_DBG_EN
    , .dbg_lfsr(b_dbg)
`endif
  );

  int n_run  = 0;
  int n_fail = 0;

  localparam logic [22:0] SEED0 = 23'h1DBFBC;
  localparam logic [22:0] SEED1 = 23'h0607BB;

  // Reference Gen3 LFSR state per lane of instance B.
  logic [22:0] m_st [2];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Bit-serial reference for x^23+x^21+x^16+x^8+x^5+x^2+1: returns
  // {keystream byte, state after 8 shifts}.
  function automatic logic [30:0] m3(input logic [22:0] st);
    logic [22:0] s;
    logic [7:0]  kb;
    logic        fb;
    s = st;
    kb = '0;
    for (int i = 0; i < 8; i++) begin
      fb    = s[22];
      kb[i] = fb;
      s     = {s[21:0], fb};
      s[2]  = s[2] ^ fb;
      s[5]  = s[5] ^ fb;
      s[8]  = s[8] ^ fb;
      s[16] = s[16] ^ fb;
      s[21] = s[21] ^ fb;
    end
    return {kb, s};
  endfunction

  task automatic a_step(input logic [7:0] d, input logic k);
    a_valid = 1'b1; a_data = d; a_k = k;
    @(posedge pclk); #1;
    a_valid = 1'b0;
  endtask

  task automatic b_g12(input string tag, input logic [63:0] d, input logic [7:0] k,
                       input logic [63:0] exp);
    b_valid = 1'b1; b_bs = 1'b0; b_data = d; b_k = k;
    @(posedge pclk); #1;
    b_valid = 1'b0;
    chk(tag, b_odata, exp);
  endtask

  // One Gen3 beat with the same 4-symbol word on both lanes.
  task automatic g3_beat(input string tag, input logic bs, input logic [1:0] sync,
                         input logic [31:0] w, input logic [3:0] mask, input logic adv);
    logic [63:0] exp;
    logic [30:0] r;
    for (int l = 0; l < 2; l++) begin
      for (int s = 0; s < 4; s++) begin
        r = m3(m_st[l]);
        exp[(l*4+s)*8 +: 8] = w[s*8 +: 8] ^ (mask[s] ? r[30:23] : 8'h00);
        if (adv) m_st[l] = r[22:0];
      end
    end
    b_valid = 1'b1; b_bs = bs; b_sync = {sync, sync}; b_data = {w, w}; b_k = '0;
    @(posedge pclk); #1;
    b_valid = 1'b0; b_bs = 1'b0;
    chk(tag, b_odata, exp);
  endtask

  task automatic b_idle(input string tag);
    b_valid = 1'b0;
    @(posedge pclk); #1;
    chk(tag, {63'd0, b_ovalid}, 64'd0);
  endtask

  task automatic data_block(input string tag, input logic [31:0] w0, input logic [31:0] w1,
                            input logic [31:0] w2, input logic [31:0] w3);
    g3_beat({tag, "_b0"}, 1'b1, 2'b01, w0, 4'hF, 1'b1);
    g3_beat({tag, "_b1"}, 1'b0, 2'b01, w1, 4'hF, 1'b1);
    g3_beat({tag, "_b2"}, 1'b0, 2'b01, w2, 4'hF, 1'b1);
    g3_beat({tag, "_b3"}, 1'b0, 2'b01, w3, 4'hF, 1'b1);
  endtask

  logic [7:0] exp_a [8];

  initial begin
    exp_a = '{8'hFF, 8'h17, 8'hC0, 8'h14, 8'hB2, 8'hE7, 8'h02, 8'h82};
    a_gen = 3'd1; a_dis = 1'b0; a_valid = 1'b0; a_bs = 1'b0; a_data = '0; a_k = '0;
    a_sync = '0; a_seed = SEED0;
    b_gen = 3'd1; b_dis = 1'b0; b_valid = 1'b0; b_bs = 1'b0; b_data = '0; b_k = '0;
    b_sync = '0; b_seed = {SEED1, SEED0};
    m_st[0] = SEED0; m_st[1] = SEED1;

    reset_n = 1'b0;
    repeat (3) @(posedge pclk);
    #1;
    chk("rst_a_valid", {63'd0, a_ovalid}, 64'd0);
    chk("rst_b_data", b_odata, 64'd0);
    chk("rst_b_err", {63'd0, b_err}, 64'd0);
    reset_n = 1'b1;
    @(posedge pclk); #1;

    // Gen1, 1 lane x 1 symbol: COM then eight D 0x00.
    a_step(8'hBC, 1'b1);
    chk("a_com", {55'd0, a_ok, a_odata}, {55'd0, 1'b1, 8'hBC});
    for (int i = 0; i < 8; i++) begin
      a_step(8'h00, 1'b0);
      chk($sformatf("a_d%0d", i), {56'd0, a_odata}, {56'd0, exp_a[i]});
    end

    // Gen1, 2 lanes x 4 symbols: COM + 3 SKP, then D 0x00 x4.
    b_g12("b_comskp", 64'h1C1C1CBC_1C1C1CBC, 8'hFF, 64'h1C1C1CBC_1C1C1CBC);
    chk("b_comskp_k", {56'd0, b_ok}, 64'h0000_0000_0000_00FF);
    b_g12("b_g1_d0", 64'd0, 8'h00, 64'h14C017FF_14C017FF);

    // Switch to Gen3 on an idle cycle: lanes reload their seeds.
    b_gen = 3'd3;
    b_idle("g3_idle");

    // Data block of zeros with an idle gap; output is the seeded keystream.
    g3_beat("dat0_b0", 1'b1, 2'b01, 32'h0, 4'hF, 1'b1);
    chk("dat0_obs", {60'd0, b_osync, 3'd0, b_obs}, {60'd0, 4'b0101, 3'd0, 1'b1});
    n_run++;
    assert (b_odata[31:0] !== b_odata[63:32]) else begin
      n_fail++;
      $error("FAIL lanes_differ: lane0 %h lane1 %h", b_odata[31:0], b_odata[63:32]);
    end
    g3_beat("dat0_b1", 1'b0, 2'b01, 32'h0, 4'hF, 1'b1);
    b_idle("dat0_gap");
    g3_beat("dat0_b2", 1'b0, 2'b01, 32'h0, 4'hF, 1'b1);
    g3_beat("dat0_b3", 1'b0, 2'b01, 32'h0, 4'hF, 1'b1);

    // SKP OS: untouched, LFSR frozen for the block.
    g3_beat("skp_b0", 1'b1, 2'b10, 32'hAAAAAAAA, 4'h0, 1'b0);
    g3_beat("skp_b1", 1'b0, 2'b10, 32'hAAAAAAAA, 4'h0, 1'b0);
    g3_beat("skp_b2", 1'b0, 2'b10, 32'hAAAAAAAA, 4'h0, 1'b0);
    g3_beat("skp_b3", 1'b0, 2'b10, 32'h563412E1, 4'h0, 1'b0);

    // Data block continuing the stream as if the SKP OS were absent.
    data_block("dat1", 32'h33221100, 32'h77665544, 32'hBBAA9988, 32'hFFEEDDCC);

    // EIEOS, then data restarting from the seed on the very next beat.
    g3_beat("eie_b0", 1'b1, 2'b10, 32'hFF00FF00, 4'h0, 1'b1);
    g3_beat("eie_b1", 1'b0, 2'b10, 32'hFF00FF00, 4'h0, 1'b1);
    g3_beat("eie_b2", 1'b0, 2'b10, 32'hFF00FF00, 4'h0, 1'b1);
    g3_beat("eie_b3", 1'b0, 2'b10, 32'hFF00FF00, 4'h0, 1'b1);
    m_st[0] = SEED0; m_st[1] = SEED1;
    data_block("dat2", 32'h0, 32'h0, 32'h0, 32'h0);

    // TS1: symbol 0 clear, symbols 1..15 scrambled, LFSR advances on all.
    g3_beat("ts1_b0", 1'b1, 2'b10, 32'h0403021E, 4'hE, 1'b1);
    chk("ts1_sym0", {56'd0, b_odata[7:0]}, 64'h1E);
    g3_beat("ts1_b1", 1'b0, 2'b10, 32'h4A4A4A4A, 4'hF, 1'b1);
    g3_beat("ts1_b2", 1'b0, 2'b10, 32'h4A4A4A4A, 4'hF, 1'b1);
    g3_beat("ts1_b3", 1'b0, 2'b10, 32'h4A4A4A4A, 4'hF, 1'b1);

    // scr_disable: pass-through while the LFSR keeps tracking.
    b_dis = 1'b1;
    g3_beat("dis_b0", 1'b1, 2'b01, 32'hDEADBEEF, 4'h0, 1'b1);
    g3_beat("dis_b1", 1'b0, 2'b01, 32'hDEADBEEF, 4'h0, 1'b1);
    g3_beat("dis_b2", 1'b0, 2'b01, 32'hDEADBEEF, 4'h0, 1'b1);
    g3_beat("dis_b3", 1'b0, 2'b01, 32'hDEADBEEF, 4'h0, 1'b1);
    b_dis = 1'b0;

    // Misalign: block start on the 2nd beat; block restarts there.
    g3_beat("mis_b0", 1'b1, 2'b01, 32'h0, 4'hF, 1'b1);
    chk("mis_err_pre", {63'd0, b_err}, 64'd0);
    g3_beat("mis_b1", 1'b1, 2'b01, 32'h0, 4'hF, 1'b1);
    chk("mis_err_set", {63'd0, b_err}, 64'd1);
    g3_beat("mis_b2", 1'b0, 2'b01, 32'h0, 4'hF, 1'b1);
    g3_beat("mis_b3", 1'b0, 2'b01, 32'h0, 4'hF, 1'b1);
    g3_beat("mis_b4", 1'b0, 2'b01, 32'h0, 4'hF, 1'b1);
    b_idle("mis_idle");
    chk("mis_err_sticky", {63'd0, b_err}, 64'd1);

    // Gen 3 -> 1 on a valid beat: that beat already uses FFFF.
    b_gen = 3'd1;
    b_g12("g31_d0", 64'd0, 8'h00, 64'h14C017FF_14C017FF);
    chk("g31_err", {63'd0, b_err}, 64'd1);

    // Gen 1 -> 3 together with a block start: seeds apply on that beat.
    b_gen = 3'd3;
    m_st[0] = SEED0; m_st[1] = SEED1;
    g3_beat("g13_b0", 1'b1, 2'b01, 32'h0, 4'hF, 1'b1);
    g3_beat("g13_b1", 1'b0, 2'b01, 32'h0, 4'hF, 1'b1);

    // Reset mid-block: everything discarded, next block start is aligned.
    reset_n = 1'b0;
    #2;
    chk("mrst_err", {63'd0, b_err}, 64'd0);
    chk("mrst_valid", {63'd0, b_ovalid}, 64'd0);
    @(posedge pclk); #1;
    reset_n = 1'b1;
    m_st[0] = SEED0; m_st[1] = SEED1;
    g3_beat("post_b0", 1'b1, 2'b01, 32'h0, 4'hF, 1'b1);
    chk("post_err", {63'd0, b_err}, 64'd0);
    g3_beat("post_b1", 1'b0, 2'b01, 32'h0, 4'hF, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
